seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode 7-segment display. It holds a 4-nibble hex value and shares one hex-to-segment decode path across all four digits. Each digit gets its own refresh slot, with a blanking gap at the start of every slot to prevent ghosting. Updates are double-buffered and committed only at frame boundaries, so a digit change never tears mid-frame.

## Interface
Parameters:
- DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); legal range ≥ 2.
- BLANK, 1000: cycles at the start of each slot with all digits off; legal range 1 ≤ BLANK < DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  16  pending hex digits; digit k = value[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  4  pending decimal points, bit k → digit k; 1 = lit.
- digit_en  in  4  pending per-digit enable; 0 = digit always dark.
- lz_blank  in  1  live (unbuffered) leading-zero suppression enable.
- load  in  1  one-cycle strobe; captures value/dp_in/digit_en into the pending register.
- busy  out  1  pending data not yet committed.
- seg  out  7  segments {a,b,c,d,e,f,g} = seg[6:0]; active-high.
- dp  out  1  decimal point; active-high.
- an  out  4  digit select, an[k] → digit k; active-low.
- frame_tick  out  1  one-cycle pulse after each frame commit.

## Operation
- Registers:
  - prescaler cnt (0..DIV-1)
  - slot index d (0..3)
  - pending {value, dp, en} and active {value, dp, en}
  - busy
- Slot FSM, two phases per slot:
  - BLANK while cnt < BLANK.
  - SHOW while cnt ≥ BLANK.
  - When cnt == DIV-1: cnt → 0 and d → d+1 mod 4. Slots run 0,1,2,3,0,…
- Frame boundary is the edge where d == 3 and cnt == DIV-1. On that edge, if busy, active ← pending and busy ← 0.
- Load handling:
  - load=1: pending ← inputs and busy ← 1, on the same edge.
  - Multiple loads within a frame: last one wins.
  - load on the frame-boundary edge: the new data goes to pending. The old pending data is committed, busy stays 1, and the new data waits for the next frame.
- Glyphs, seg[6:0] = abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Digit k is dark if active en[k]=0, or if lz_blank=1 and active nibbles 3..k are all zero (k ≥ 1). Digit 0 is never blanked by lz_blank.
- Output selection:
  - BLANK phase or dark digit: an=1111, seg=0000000, dp=0.
  - Otherwise: an = ~(1<<d), seg = glyph(active nibble d), dp = active dp[d].
- Reset state:
  - cnt=0, d=0, busy=0, frame_tick=0.
  - pending and active all zero, en=0000, so the display is dark until the first load commits.
  - an=1111, seg=0000000, dp=0.

## Timing
- seg, an, dp, frame_tick, busy are registered.
- Display outputs lag the (cnt,d) state by one cycle. The state at cycle t appears on the outputs at cycle t+1.
- Per slot: BLANK cycles dark, then DIV-BLANK cycles lit. Frame period = 4·DIV cycles.
- busy rises the cycle after a load edge and falls the cycle after the commit edge.
- frame_tick is high for exactly one cycle, in the cycle after every frame boundary edge, whether or not a commit happened. It is never asserted out of reset.
- The new active data is first visible in the SHOW phase of digit 0 of the following frame.
- rst asserted mid-slot: the next cycle shows reset values and pending data is discarded. Scanning restarts at d=0, cnt=0 after rst deasserts.

## Test plan
All scenarios use DIV=8, BLANK=2.
1. **Reset:** rst high 3 cycles, then no load for 64 cycles → an=1111, seg=0000000, dp=0, busy=0 throughout; frame_tick pulses every 32 cycles.
2. **Basic display:** load value=16'h1234, dp_in=0000, digit_en=1111 → busy=1 until frame_tick. Next frame, each slot shows 2 dark cycles then 6 cycles of:
   - an=1110, seg=0110011 (digit 0 = 4)
   - an=1101, seg=1111001 (digit 1 = 3)
   - an=1011, seg=1101101 (digit 2 = 2)
   - an=0111, seg=0110000 (digit 3 = 1)
3. **Leading-zero suppression:** lz_blank=1 with value=16'h00A0 → an stays 1111 in slots 3 and 2; slot 1 shows seg=1110111; slot 0 shows seg=1111110. With value=16'h0000, only slot 0 lights (seg=1111110).
4. **Double buffering:**
   - load 16'h1111, then load 16'h2222 within the same frame → only 2222 is displayed next frame.
   - load 16'h3333 exactly on the boundary edge → current pending commits, busy stays 1, and 3333 appears one frame later.
5. **Enables and decimal point:** digit_en=1101, dp_in=0100 → an[1] never low; dp=1 only during the SHOW phase of slot 2; dp=0 in all other cycles.
6. **Mid-slot reset:** rst pulsed for 1 cycle during slot d=2 with busy=1 → next cycle an=1111, busy=0; the display stays dark after restart until a new load commits.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode 7-segment scanner: one shared hex decoder, a blanking gap at the
// start of every digit slot, and double-buffered data that only changes at frame boundaries.
module seg7_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  digit_en,
  input  logic        lz_blank,
  input  logic        load,
  output logic        busy,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

  typedef enum logic {P_BLANK, P_SHOW} phase_t;

  phase_t      phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]  d;
  logic [15:0] pend_val;
  logic [3:0]  pend_dp;
  logic [3:0]  pend_en;
  logic [15:0] act_val;
  logic [3:0]  act_dp;
  logic [3:0]  act_en;

  logic        slot_end;
  logic        boundary;
  logic [3:1]  zero_hi;
  logic [3:0]  dark;
  logic [3:0]  nib;
  logic        lit;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return g;
  endfunction

  always_comb begin
    slot_end   = (cnt == CNT_LAST);
    boundary   = slot_end && (d == 2'd3);
    cnt_next   = slot_end ? '0 : cnt + 1'b1;
    // zero_hi[k]: nibbles 3..k are all zero, i.e. digit k is a leading zero
    zero_hi[3] = (act_val[15:12] == 4'h0);
    zero_hi[2] = zero_hi[3] && (act_val[11:8] == 4'h0);
    zero_hi[1] = zero_hi[2] && (act_val[7:4] == 4'h0);
    dark       = ~act_en | ({4{lz_blank}} & {zero_hi, 1'b0});
    nib        = act_val[{d, 2'b00} +: 4];
    lit        = (phase == P_SHOW) && !dark[d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= P_BLANK;
      cnt        <= '0;
      d          <= 2'd0;
      pend_val   <= 16'h0;
      pend_dp    <= 4'h0;
      pend_en    <= 4'h0;
      act_val    <= 16'h0;
      act_dp     <= 4'h0;
      act_en     <= 4'h0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h00;
      dp         <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      phase      <= (cnt_next < CNT_BLANK) ? P_BLANK : P_SHOW;
      if (slot_end) d <= d + 2'd1;
      frame_tick <= boundary;

      if (boundary && busy) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        act_en  <= pend_en;
      end

      // A load on the boundary edge wins over the clear, so its data waits a frame
      if (load) begin
        pend_val <= value;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
        busy     <= 1'b1;
      end else if (boundary) begin
        busy     <= 1'b0;
      end

      if (lit) begin
        an  <= ~(4'b0001 << d);
        seg <= glyph(nib);
        dp  <= act_dp[d];
      end else begin
        an  <= 4'hF;
        seg <= 7'h00;
        dp  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV=8, BLANK=2 (32-cycle frames).
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'h0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        busy;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .load(load), .busy(busy), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_to(input int m);
    while (cyc % 32 != m) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en);
    value = v; dp_in = dpv; digit_en = en; load = 1'b1;
    tick();
    load = 1'b0;
    chk("busy_after_load", 16'(busy), 16'h1);
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "/an"}, 16'(an), 16'hF);
    chk({tag, "/seg"}, 16'(seg), 16'h0);
    chk({tag, "/dp"}, 16'(dp), 16'h0);
  endtask

  // One full frame starting at slot 0, cnt 0; g[k] is the glyph expected on digit k
  task automatic frame(input string tag, input logic [3:0][6:0] g, input logic [3:0] lit_mask,
                       input logic [3:0] dp_mask, input logic exp_busy);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 8; c++) begin
        logic       on;
        logic       last;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        tick();
        on   = (c >= 2) && lit_mask[s];
        last = (s == 3) && (c == 7);
        ean  = on ? ~(4'b0001 << s) : 4'hF;
        eseg = on ? g[s] : 7'h00;
        edp  = on ? dp_mask[s] : 1'b0;
        chk({tag, "/an"}, 16'(an), 16'(ean));
        chk({tag, "/seg"}, 16'(seg), 16'(eseg));
        chk({tag, "/dp"}, 16'(dp), 16'(edp));
        chk({tag, "/frame_tick"}, 16'(frame_tick), 16'(last));
        chk({tag, "/busy"}, 16'(busy), last ? 16'h0 : 16'(exp_busy));
      end
    end
  endtask

  initial begin
    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_dark("reset");
      chk("reset/busy", 16'(busy), 16'h0);
      chk("reset/frame_tick", 16'(frame_tick), 16'h0);
    end
    rst = 1'b0;
    cyc = 0;

    frame("idle0", 28'h0, 4'b0000, 4'b0000, 1'b0);
    frame("idle1", 28'h0, 4'b0000, 4'b0000, 1'b0);

    // Basic display of 1234
    do_load(16'h1234, 4'b0000, 4'b1111);
    idle_to(31);
    chk("pre_commit/busy", 16'(busy), 16'h1);
    chk("pre_commit/frame_tick", 16'(frame_tick), 16'h0);
    tick();
    chk("commit/frame_tick", 16'(frame_tick), 16'h1);
    chk("commit/busy", 16'(busy), 16'h0);
    frame("hex1234", {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b1111, 4'b0000, 1'b0);

    // Leading-zero suppression
    lz_blank = 1'b1;
    do_load(16'h00A0, 4'b0000, 4'b1111);
    idle_to(0);
    frame("lz00A0", {7'b0, 7'b0, 7'b1110111, 7'b1111110}, 4'b0011, 4'b0000, 1'b0);
    do_load(16'h0000, 4'b0000, 4'b1111);
    idle_to(0);
    frame("lz0000", {7'b0, 7'b0, 7'b0, 7'b1111110}, 4'b0001, 4'b0000, 1'b0);
    lz_blank = 1'b0;

    // Two loads in one frame: last one wins
    do_load(16'h1111, 4'b0000, 4'b1111);
    for (int i = 0; i < 5; i++) tick();
    do_load(16'h2222, 4'b0000, 4'b1111);
    idle_to(0);
    frame("dbuf2222", {4{7'b1101101}}, 4'b1111, 4'b0000, 1'b0);

    // Load exactly on the boundary edge
    do_load(16'h4444, 4'b0000, 4'b1111);
    idle_to(31);
    do_load(16'h3333, 4'b0000, 4'b1111);
    chk("bnd/frame_tick", 16'(frame_tick), 16'h1);
    frame("bnd4444", {4{7'b0110011}}, 4'b1111, 4'b0000, 1'b1);
    frame("bnd3333", {4{7'b1111001}}, 4'b1111, 4'b0000, 1'b0);

    // Per-digit enable and decimal point
    do_load(16'h8888, 4'b0100, 4'b1101);
    idle_to(0);
    frame("en_dp", {4{7'b1111111}}, 4'b1101, 4'b0100, 1'b0);

    // Mid-slot reset with data pending
    do_load(16'h1234, 4'b0000, 4'b1111);
    idle_to(20);
    chk("pre_rst/an", 16'(an), 16'hB);
    chk("pre_rst/seg", 16'(seg), 16'h7F);
    chk("pre_rst/busy", 16'(busy), 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_dark("mid_rst");
    chk("mid_rst/busy", 16'(busy), 16'h0);
    chk("mid_rst/frame_tick", 16'(frame_tick), 16'h0);
    cyc = 0;
    frame("post_rst0", 28'h0, 4'b0000, 4'b0000, 1'b0);
    frame("post_rst1", 28'h0, 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
